keypad_scanner: RTL and testbench

Front end that produces the `keystroke` bus consumed by `core`. Drives the columns of a 4-row by 3-column matrix keypad, samples the rows, and debounces whole scan frames. Outputs a clean 12-bit key-level vector plus one-cycle press pulses. Replaces the hand-driven `keystroke` stimulus with the real board-side source of those signals.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/scan_divider.sv | 54 +++++
 rtl/keypad_scanner.sv | 108 ++++++++++
 tb/tb_keypad_scanner.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad geometry and key-index helper used by the scanner and by core.
package keypad_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 3;
    localparam int KEY_W    = KEY_ROWS * KEY_COLS;

    typedef logic [KEY_W-1:0]    key_vec_t;
    typedef logic [KEY_ROWS-1:0] row_vec_t;
    typedef logic [KEY_COLS-1:0] col_vec_t;

    // Bit position of a key in the keystroke vector: columns are nibbles.
    function automatic int key_idx(input int col, input int row);
        return col * KEY_ROWS + row;
    endfunction

endpackage

// File: rtl/scan_divider.sv
// Column scan timebase: holds each column for SCAN_DIV cycles, walks the
// columns round-robin and flags the last dwell cycle as the row sample point.
module scan_divider #(
    parameter int SCAN_DIV = 100000,
    parameter int N_COLS   = 3,
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
    localparam int COL_W   = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic             clk_raw,
    input  logic             rst_n,
    output logic [COL_W-1:0] col,
    output logic [N_COLS-1:0] col_n,
    output logic             sample
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [N_COLS-1:0] col_n_q, col_n_d;
    logic              wrap;

    // Next dwell count, column index and the matching active-low column drive.
    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        wrap    = (div_q == DIV_LAST);
        div_d   = wrap ? '0 : div_q + 1'b1;
        col_d   = col_q;
        if (wrap) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
        col_n_d = ~(N_COLS'(1) << col_d);
    end

    // Dwell counter, column index and registered column drive.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            col_q   <= '0;
            col_n_q <= ~N_COLS'(1);
        end else begin
            div_q   <= div_d;
            col_q   <= col_d;
            col_n_q <= col_n_d;
        end
    end

    assign col    = col_q;
    assign col_n  = col_n_q;
    assign sample = (div_q == DIV_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad front end: drives columns, synchronizes and samples the
// rows, debounces complete scan frames and reports key levels plus press pulses.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk_raw,
    input  logic                rst_n,
    input  logic [KEY_ROWS-1:0] row_in,
    output logic [KEY_COLS-1:0] col_out,
    output logic [KEY_W-1:0]    keystroke,
    output logic [KEY_W-1:0]    key_press
);

    localparam int COL_W = $clog2(KEY_COLS);
    localparam int ST_W  = $clog2(DEBOUNCE + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(KEY_COLS - 1);
    localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(DEBOUNCE);

    logic [COL_W-1:0] col;
    logic             sample;

    row_vec_t         row_meta_q, row_s_q;
    row_vec_t         rows_pressed;
    key_vec_t         col_mask, col_bits;
    key_vec_t         frame_q, frame_d;
    key_vec_t         prev_q, prev_d;
    logic [ST_W-1:0]  stable_q, stable_d;
    key_vec_t         keystroke_q, keystroke_d;
    key_vec_t         key_press_q, key_press_d;

    scan_divider #(
        .SCAN_DIV (SCAN_DIV),
        .N_COLS   (KEY_COLS)
    ) u_scan_divider (
        .clk_raw (clk_raw),
        .rst_n   (rst_n),
        .col     (col),
        .col_n   (col_out),
        .sample  (sample)
    );

    // Two-flop synchronizer for the asynchronous rows; idles at "no key".
    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '1;
            row_s_q    <= '1;
        end else begin
            row_meta_q <= row_in;
            row_s_q    <= row_meta_q;
        end
    end

    // Frame assembly and debounce decision, evaluated at the sample strobe.
    always_comb begin
        frame_d      = frame_q;
        prev_d       = prev_q;
        stable_d     = stable_q;
        keystroke_d  = keystroke_q;
        key_press_d  = '0;
        rows_pressed = ~row_s_q;
        col_mask     = KEY_W'({KEY_ROWS{1'b1}}) << key_idx(int'(col), 0);
        col_bits     = KEY_W'(rows_pressed) << key_idx(int'(col), 0);

        if (sample) begin
            frame_d = (frame_q & ~col_mask) | col_bits;

            // The last column completes a frame: compare it with the previous one.
            if (col == COL_LAST) begin
                if (frame_d == prev_q) begin
                    stable_d = (stable_q == ST_MAX) ? stable_q : stable_q + 1'b1;
                end else begin
                    stable_d = '0;
                end
                prev_d = frame_d;

                // Saturation alone never recommits: only a real change updates keystroke.
                if ((stable_d == ST_MAX) && (frame_d != keystroke_q)) begin
                    keystroke_d = frame_d;
                    key_press_d = frame_d & ~keystroke_q;
                end
            end
        end
    end

    // Frame, previous frame, debounce count and registered outputs.
    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            frame_q     <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            keystroke_q <= '0;
            key_press_q <= '0;
        end else begin
            frame_q     <= frame_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            keystroke_q <= keystroke_d;
            key_press_q <= key_press_d;
        end
    end

    assign keystroke = keystroke_q;
    assign key_press = key_press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model closes the
// column/row loop, and a frame-level run-length model predicts the outputs.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = 3 * SCAN_DIV;

    logic        clk_raw = 1'b0;
    logic        rst_n   = 1'b0;
    logic [3:0]  row_in  = 4'hF;
    logic [2:0]  col_out;
    logic [11:0] keystroke;
    logic [11:0] key_press;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk_raw   (clk_raw),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_out   (col_out),
        .keystroke (keystroke),
        .key_press (key_press)
    );

    always #5 clk_raw = ~clk_raw;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cycles = 0;

    // Physical keypad state and per-frame observations.
    logic [11:0] pressed = '0;
    logic [2:0]  obs_cols [1:FRAME];
    logic [11:0] obs_mid_ks, obs_mid_kp, obs_end_ks, obs_end_kp;
    logic        obs_mid_ks_ok;

    // Reference model: history of whole frames since reset, led by the all-zero
    // frame the scanner starts from; a level commits once it has been seen in
    // DEBOUNCE+1 consecutive frames and differs from the reported level.
    logic [11:0] frames [$];
    logic [11:0] m_ks, m_kp;

    function automatic logic [3:0] keypad_rows(input logic [2:0] cols, input logic [11:0] keys);
        logic [3:0] r;
        r = 4'hF;
        for (int c = 0; c < 3; c++)
            if (!cols[c])
                for (int k = 0; k < 4; k++)
                    if (keys[key_idx(c, k)]) r[k] = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        frames.delete();
        frames.push_back(12'h000);
        m_ks = '0;
        m_kp = '0;
    endtask

    task automatic model_frame(input logic [11:0] f);
        int run;
        frames.push_back(f);
        run = 0;
        for (int j = frames.size() - 1; j >= 0; j--) begin
            if (frames[j] == f) run++;
            else break;
        end
        m_kp = '0;
        if (run >= DEBOUNCE + 1 && f != m_ks) begin
            m_kp = f & ~m_ks;
            m_ks = f;
        end
    endtask

    task automatic drive_rows();
        row_in = keypad_rows(col_out, pressed);
    endtask

    // Holds one key set for a whole frame, starting at the negedge of its first
    // cycle; records what the DUT shows mid-frame and right after the commit edge.
    task automatic run_frame(input logic [11:0] keys);
        pressed = keys;
        drive_rows();
        obs_mid_kp    = '0;
        obs_mid_ks_ok = 1'b1;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk_raw);
            drive_rows();
            obs_cols[i] = col_out;
            if (key_press != 12'h000) pulse_cycles++;
            if (i == 1) obs_mid_ks = keystroke;
            if (i < FRAME) begin
                obs_mid_kp = obs_mid_kp | key_press;
                if (keystroke !== obs_mid_ks) obs_mid_ks_ok = 1'b0;
            end else begin
                obs_end_ks = keystroke;
                obs_end_kp = key_press;
            end
        end
        model_frame(keys);
    endtask

    task automatic test_reset();
        @(negedge clk_raw);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_raw);
        vectors += 3;
        if (col_out !== 3'b110) begin miscompares++; $display("FAIL reset_col_out got %b expected 110", col_out); end
        if (keystroke !== 12'h000) begin miscompares++; $display("FAIL reset_keystroke got %h expected 000", keystroke); end
        if (key_press !== 12'h000) begin miscompares++; $display("FAIL reset_key_press got %h expected 000", key_press); end
        rst_n = 1'b1;
        model_reset();
        vectors += 2;
        if (col_out !== 3'b110) begin miscompares++; $display("FAIL release_col_out got %b expected 110", col_out); end
        if (keystroke !== 12'h000) begin miscompares++; $display("FAIL release_keystroke got %h expected 000", keystroke); end
    endtask

    task automatic test_free_run();
        logic [2:0] exp_col;
        int p0;
        p0 = pulse_cycles;
        for (int f = 0; f < 3; f++) begin
            run_frame(12'h000);
            for (int i = 1; i <= FRAME; i++) begin
                exp_col = ~(3'b001 << ((i / SCAN_DIV) % 3));
                vectors++;
                if (obs_cols[i] !== exp_col) begin
                    miscompares++;
                    $display("FAIL free_run_col frame %0d cycle %0d got %b expected %b", f, i, obs_cols[i], exp_col);
                end
            end
            vectors++;
            if (obs_end_ks !== 12'h000 || !obs_mid_ks_ok || obs_mid_ks !== 12'h000) begin
                miscompares++;
                $display("FAIL free_run_keystroke frame %0d got %h expected 000", f, obs_end_ks);
            end
        end
        vectors++;
        if (pulse_cycles - p0 !== 0) begin miscompares++; $display("FAIL free_run_pulses got %0d expected 0", pulse_cycles - p0); end
    endtask

    task automatic test_toggle();
        int p0;
        logic [11:0] prev_ks;
        p0 = pulse_cycles;
        for (int f = 0; f < 10; f++) begin
            prev_ks = m_ks;
            run_frame((f % 2 == 0) ? 12'h040 : 12'h000);
            vectors += 2;
            if (obs_end_ks !== m_ks || obs_end_ks !== 12'h000) begin
                miscompares++;
                $display("FAIL toggle_keystroke frame %0d got %h expected %h", f, obs_end_ks, m_ks);
            end
            if (obs_mid_ks !== prev_ks || !obs_mid_ks_ok) begin
                miscompares++;
                $display("FAIL toggle_mid_keystroke frame %0d got %h expected %h", f, obs_mid_ks, prev_ks);
            end
        end
        vectors++;
        if (pulse_cycles - p0 !== 0) begin miscompares++; $display("FAIL toggle_pulses got %0d expected 0", pulse_cycles - p0); end
    endtask

    // Holds one key set for n frames; the commit must land after frame DEBOUNCE+1.
    task automatic test_hold(input string name, input logic [11:0] keys, input logic [11:0] exp_ks,
                             input logic [11:0] exp_kp, input int exp_pulses);
        int p0;
        logic [11:0] prev_ks;
        p0 = pulse_cycles;
        prev_ks = m_ks;
        for (int f = 1; f <= DEBOUNCE + 2; f++) begin
            run_frame(keys);
            vectors += 3;
            if (obs_end_ks !== ((f >= DEBOUNCE + 1) ? exp_ks : prev_ks) || obs_end_ks !== m_ks) begin
                miscompares++;
                $display("FAIL %s_keystroke frame %0d got %h expected %h", name, f, obs_end_ks, m_ks);
            end
            if (obs_end_kp !== ((f == DEBOUNCE + 1) ? exp_kp : 12'h000) || obs_end_kp !== m_kp) begin
                miscompares++;
                $display("FAIL %s_key_press frame %0d got %h expected %h", name, f, obs_end_kp, m_kp);
            end
            if (obs_mid_kp !== 12'h000 || !obs_mid_ks_ok) begin
                miscompares++;
                $display("FAIL %s_mid_frame frame %0d got kp %h expected 000", name, f, obs_mid_kp);
            end
        end
        vectors++;
        if (pulse_cycles - p0 !== exp_pulses) begin
            miscompares++;
            $display("FAIL %s_pulse_cycles got %0d expected %0d", name, pulse_cycles - p0, exp_pulses);
        end
    endtask

    task automatic test_reset_mid();
        // Two frames of a new key leave the debounce count part-way up.
        for (int f = 0; f < 2; f++) run_frame(12'h040);
        pressed = 12'h040;
        drive_rows();
        repeat (5) begin
            @(negedge clk_raw);
            drive_rows();
        end
        #1 rst_n = 1'b0;
        #1;
        vectors += 3;
        if (keystroke !== 12'h000) begin miscompares++; $display("FAIL reset_mid_keystroke got %h expected 000", keystroke); end
        if (key_press !== 12'h000) begin miscompares++; $display("FAIL reset_mid_key_press got %h expected 000", key_press); end
        if (col_out !== 3'b110) begin miscompares++; $display("FAIL reset_mid_col_out got %b expected 110", col_out); end
        @(negedge clk_raw);
        rst_n = 1'b1;
        model_reset();
        vectors++;
        if (col_out !== 3'b110) begin miscompares++; $display("FAIL reset_mid_release_col_out got %b expected 110", col_out); end
        test_hold("reset_mid_repress", 12'h040, 12'h040, 12'h040, 1);
    endtask

    task automatic test_random();
        logic [11:0] keys, prev_ks;
        int hold;
        keys = '0;
        for (int f = 0; f < 40; f++) begin
            if (hold == 0 || f == 0) begin
                keys = 12'($urandom & $urandom);
                hold = $urandom_range(1, 4);
            end
            hold--;
            prev_ks = m_ks;
            run_frame(keys);
            vectors += 3;
            if (obs_end_ks !== m_ks) begin
                miscompares++;
                $display("FAIL random_keystroke frame %0d got %h expected %h", f, obs_end_ks, m_ks);
            end
            if (obs_end_kp !== m_kp) begin
                miscompares++;
                $display("FAIL random_key_press frame %0d got %h expected %h", f, obs_end_kp, m_kp);
            end
            if (obs_mid_ks !== prev_ks || !obs_mid_ks_ok || obs_mid_kp !== 12'h000) begin
                miscompares++;
                $display("FAIL random_mid_frame frame %0d got ks %h kp %h expected ks %h kp 000", f, obs_mid_ks, obs_mid_kp, prev_ks);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_toggle();
        test_hold("press", 12'h040, 12'h040, 12'h040, 1);
        test_hold("release", 12'h000, 12'h000, 12'h000, 0);
        test_hold("multi", 12'h801, 12'h801, 12'h801, 1);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
